// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM states, frame width and the cpol/cpha mode pair.
// Used by both ends of the link.
package spi_pkg;

   localparam int SPI_DATA_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } state_t;

   typedef struct packed {
      logic cpol;
      logic cpha;
   } mode_t;

   // Leading edge is the transition away from the idle sclk level.
   function automatic logic lead_edge(input mode_t m, input logic rise, input logic fall);
      return m.cpol ? fall : rise;
   endfunction

endpackage

// File: rtl/spi_slave_if.sv
// SPI pin bundle between a master and a responder.
interface spi_slave_if;
   logic sclk;
   logic ss_n;
   logic mosi;
   logic miso;
   logic miso_oe;

   modport master (output sclk, output ss_n, output mosi, input miso, input miso_oe);
   modport slave  (input sclk, input ss_n, input mosi, output miso, output miso_oe);
endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin, with one extra flop
// providing single-cycle rise/fall pulses on the synchronised level.
module spi_sync_edge #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RESET_VAL   = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] chain_r;
   logic                   prev_r;

   // Synchroniser chain plus the history flop used for edge detection.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         chain_r <= {SYNC_STAGES{RESET_VAL}};
         prev_r  <= RESET_VAL;
      end else begin
         chain_r <= {chain_r[SYNC_STAGES-2:0], d};
         prev_r  <= chain_r[SYNC_STAGES-1];
      end
   end

   assign q    = chain_r[SYNC_STAGES-1];
   assign rise = chain_r[SYNC_STAGES-1] & ~prev_r;
   assign fall = ~chain_r[SYNC_STAGES-1] & prev_r;

endmodule

// File: rtl/spi_slave.sv
// SPI responder: oversampled sclk/ss_n/mosi, all four modes, MSB-first frames,
// single-entry transmit buffer reloaded at every frame/byte boundary.
module spi_slave
   import spi_pkg::*;
#(
   parameter int DATA_WIDTH  = SPI_DATA_WIDTH,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cpol,
   input  logic                  cpha,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  wr_tx,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  rx_done_tick,
   output logic                  tx_empty,
   output logic                  busy,
   spi_slave_if.slave            spi
);

   localparam int              CNT_W    = $clog2(DATA_WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic sclk_unused_q_s, sclk_rise_s, sclk_fall_s;
   logic ss_q_s, ss_rise_s, ss_fall_s;
   logic mosi_q_s, mosi_unused_rise_s, mosi_unused_fall_s;

   state_t                state_r, state_next_s;
   mode_t                 mode_r;
   logic [DATA_WIDTH-1:0] tx_buf_r, tx_shift_r, rx_shift_r, dout_r;
   logic [CNT_W-1:0]      bit_cnt_r;
   logic                  tx_empty_r, skip_r, tick_r;
   logic                  lead_s, trail_s, sample_s, shift_edge_s, load_s;
   logic                  busy_s, oe_s;

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
      .clk(clk), .reset(reset), .d(spi.sclk),
      .q(sclk_unused_q_s), .rise(sclk_rise_s), .fall(sclk_fall_s)
   );

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
      .clk(clk), .reset(reset), .d(spi.ss_n),
      .q(ss_q_s), .rise(ss_rise_s), .fall(ss_fall_s)
   );

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
      .clk(clk), .reset(reset), .d(spi.mosi),
      .q(mosi_q_s), .rise(mosi_unused_rise_s), .fall(mosi_unused_fall_s)
   );

   // Map detected sclk edges onto sample/shift roles for the latched mode.
   always_comb begin
      lead_s       = lead_edge(mode_r, sclk_rise_s, sclk_fall_s);
      trail_s      = lead_edge(mode_r, sclk_fall_s, sclk_rise_s);
      sample_s     = mode_r.cpha ? trail_s : lead_s;
      shift_edge_s = mode_r.cpha ? lead_s : trail_s;
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state logic; a completing 8th sample wins over a simultaneous deselect.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE:  state_next_s = ss_fall_s ? ST_SHIFT : ST_IDLE;
         ST_SHIFT: begin
            if (sample_s && (bit_cnt_r == LAST_BIT)) begin
               state_next_s = ST_DONE;
            end else if (ss_rise_s) begin
               state_next_s = ST_IDLE;
            end else begin
               state_next_s = ST_SHIFT;
            end
         end
         ST_DONE:  state_next_s = ss_q_s ? ST_IDLE : ST_SHIFT;
         default:  state_next_s = ST_IDLE;
      endcase
   end

   // State-decoded outputs.
   always_comb begin
      busy_s = 1'b0;
      oe_s   = 1'b0;
      case (state_r)
         ST_IDLE:  begin busy_s = 1'b0; oe_s = 1'b0; end
         ST_SHIFT: begin busy_s = 1'b1; oe_s = 1'b1; end
         ST_DONE:  begin busy_s = 1'b1; oe_s = 1'b1; end
         default:  begin busy_s = 1'b0; oe_s = 1'b0; end
      endcase
   end

   // A transmit load happens at frame start and at every in-burst byte boundary.
   always_comb begin
      if ((state_r == ST_IDLE) && ss_fall_s) begin
         load_s = 1'b1;
      end else if ((state_r == ST_DONE) && !ss_q_s) begin
         load_s = 1'b1;
      end else begin
         load_s = 1'b0;
      end
   end

   // Transmit buffer; a same-cycle write beats the load's empty flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_buf_r   <= {DATA_WIDTH{1'b0}};
         tx_empty_r <= 1'b1;
      end else if (wr_tx) begin
         tx_buf_r   <= din;
         tx_empty_r <= 1'b0;
      end else if (load_s) begin
         tx_empty_r <= 1'b1;
      end
   end

   // Shift datapath; skip_r swallows the shift edge that precedes the first bit.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_shift_r <= {DATA_WIDTH{1'b0}};
         rx_shift_r <= {DATA_WIDTH{1'b0}};
         bit_cnt_r  <= {CNT_W{1'b0}};
         skip_r     <= 1'b0;
         mode_r     <= '{cpol: 1'b0, cpha: 1'b0};
      end else if (load_s) begin
         tx_shift_r <= wr_tx ? din : tx_buf_r;
         rx_shift_r <= {DATA_WIDTH{1'b0}};
         bit_cnt_r  <= {CNT_W{1'b0}};
         skip_r     <= (state_r == ST_DONE) ? 1'b1 : cpha;
         if (state_r == ST_IDLE) begin
            mode_r <= '{cpol: cpol, cpha: cpha};
         end
      end else if (state_r == ST_SHIFT) begin
         if (sample_s) begin
            rx_shift_r <= {rx_shift_r[DATA_WIDTH-2:0], mosi_q_s};
            bit_cnt_r  <= bit_cnt_r + CNT_ONE;
         end
         if (shift_edge_s && skip_r) begin
            skip_r <= 1'b0;
         end else if (shift_edge_s) begin
            tx_shift_r <= {tx_shift_r[DATA_WIDTH-2:0], 1'b0};
         end
      end
   end

   // Received-byte presentation.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dout_r <= {DATA_WIDTH{1'b0}};
         tick_r <= 1'b0;
      end else if (state_r == ST_DONE) begin
         dout_r <= rx_shift_r;
         tick_r <= 1'b1;
      end else begin
         tick_r <= 1'b0;
      end
   end

   assign dout         = dout_r;
   assign rx_done_tick = tick_r;
   assign tx_empty     = tx_empty_r;
   assign busy         = busy_s;
   assign spi.miso     = tx_shift_r[DATA_WIDTH-1];
   assign spi.miso_oe  = oe_s;

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI responder: the far-end counterpart of the team's SPI master; sits behind an SoC wrapper register block.
- Oversamples external sclk/ss_n/mosi on the system clock.
- Supports all four cpol/cpha modes; shifts 8 bits MSB-first in each direction.
- Presents received bytes and accepts the next transmit byte through a single-entry transmit buffer.

Parameters:
- DATA_WIDTH, 8, frame width in bits; only 8 is verified.
- SYNC_STAGES, 2, flip-flop depth of the input synchronisers (≥2).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- cpol  input  1  clock polarity; static while ss_n low
- cpha  input  1  clock phase; static while ss_n low
- din  input  8  transmit byte from wrapper
- wr_tx  input  1  one-cycle strobe that writes din into tx_buf
- dout  output  8  last complete received byte
- rx_done_tick  output  1  one-cycle pulse when dout updates
- tx_empty  output  1  tx_buf has been consumed; wrapper may write
- busy  output  1  ss_n asserted, frame in progress
- sclk  input  1  SPI clock from master, asynchronous
- ss_n  input  1  slave select, active-low, asynchronous
- mosi  input  1  master data in
- miso  output  1  slave data out
- miso_oe  output  1  tri-state enable for miso pad; high only while selected

Behaviour:
- Reset (reset=0) values:
  - State idle; dout=0; rx_done_tick=0; busy=0; miso=0; miso_oe=0.
  - tx_buf=0; tx_empty=1; shift registers 0; bit counter 0.
- Input synchronisation:
  - sclk, ss_n and mosi each pass through SYNC_STAGES flops.
  - One extra flop per line forms rise/fall detect.
  - Pin-to-detected-edge latency is SYNC_STAGES+1 clk cycles (3 by default).
- Timing constraints on the master:
  - sclk half-period ≥ 4 clk cycles, i.e. master dvsr ≥ 3.
  - ss_n falls ≥ 4 clk cycles before the first sclk edge.
- Edge roles:
  - leading = rising when cpol=0, falling when cpol=1.
  - cpha=0: sample mosi on leading, shift miso on trailing.
  - cpha=1: shift miso on leading, sample mosi on trailing.
- FSM states:
  - idle: miso_oe=0, busy=0.
    - On detected ss_n fall: copy tx_buf into tx_shift; set tx_empty=1; clear bit counter; go to shift.
    - miso = tx_shift[7] is valid in the same cycle (needed for cpha=0 first bit).
  - shift: busy=1, miso_oe=1, miso=tx_shift[7].
    - Sample edge: rx_shift <= {rx_shift[6:0], mosi_sync}; bit counter increments.
    - Shift edge: tx_shift <= {tx_shift[6:0], 0}.
    - cpha=1 exception: the first leading edge of a frame does not shift.
  - done: entered after the 8th sample edge; lasts one cycle.
    - dout <= rx_shift; rx_done_tick=1.
    - If ss_n is still low: reload tx_shift from tx_buf, set tx_empty=1, return to shift (multi-byte burst).
    - Otherwise go to idle.
- Transmit buffer:
  - wr_tx loads tx_buf and clears tx_empty in any state.
  - If a reload coincides with wr_tx, the new din is the byte loaded; tx_empty stays 0.
  - Underrun: if tx_empty=1 at reload, the stale tx_buf contents are resent; no error flag.
- Abort: ss_n rising mid-byte (bit counter 1–7) forces idle next cycle.
  - No rx_done_tick; dout unchanged; partial rx_shift discarded; miso_oe=0.
- ss_n rising in the same cycle as the 8th sample edge: the byte completes (done, then idle).
- cpol/cpha changes while busy=1 are undefined; they are sampled only at the idle-to-shift transition.
- Asynchronous reset mid-frame: all outputs return to reset values immediately.
  - The next frame begins only on a fresh ss_n fall after reset release.

Decomposition:
- Shared package spi_pkg:
  - state enum {idle, shift, done};
  - SPI_DATA_WIDTH=8 constant;
  - mode typedef struct {cpol, cpha}.
- The master uses the same package when refactored.
- One sub-module: spi_sync_edge.
  - Parameterised SYNC_STAGES synchroniser plus rise/fall pulse outputs.
  - Instantiated three times (sclk, ss_n, mosi); mosi uses only the sync output.

Test Plan:
- Modes 0–3, back-to-back with the team SPI master at dvsr=3: master din=0xA5, slave tx_buf=0x3C.
  - Required: master dout=0x3C; slave dout=0xA5; exactly one rx_done_tick per mode.
- Burst of 3 bytes under one ss_n low, mode 0: mosi 0x01,0x02,0x03; tx writes 0x11,0x22 timed on tx_empty, third byte not written.
  - Required: three ticks with dout=0x01/0x02/0x03; miso carries 0x11,0x22,0x22 (underrun resend).
- Abort: ss_n raised after 4 sclk cycles, mode 1, preceded by a complete byte 0x5A.
  - Required: no tick; dout stays 0x5A; miso_oe=0 within 4 clk cycles.
- wr_tx on the same cycle as the ss_n-fall reload, din=0xC3, previous tx_buf=0x00.
  - Required: first miso byte 0xC3; tx_empty=0 afterwards.
- Reset asserted at bit 5 of a frame.
  - Required: dout=0, busy=0, miso_oe=0, tx_empty=1 immediately.
  - A subsequent full frame with 0x96 yields dout=0x96.
- Idle sclk toggling with ss_n=1.
  - Required: no state change; no tick; miso_oe=0 throughout.
